// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type, load/store funct3 encodings and the
// store-lane / alignment helpers used by the memory stage.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } st_lanes_t;

  // Byte strobes and lane-replicated write data for a store; unknown sizes act as SW.
  function automatic st_lanes_t store_lanes(input logic [2:0]  funct3,
                                            input logic [1:0]  off,
                                            input logic [31:0] data);
    st_lanes_t l;
    case (funct3)
      F3_SB: begin
        l.wstrb = 4'b0001 << off;
        l.wdata = {4{data[7:0]}};
      end
      F3_SH: begin
        l.wstrb = 4'b0011 << {off[1], 1'b0};
        l.wdata = {2{data[15:0]}};
      end
      default: begin
        l.wstrb = 4'b1111;
        l.wdata = data;
      end
    endcase
    return l;
  endfunction

  // Halfword accesses need an even address, word accesses a 4-byte aligned one.
  // The load encodings double as SH/SW since they share the same values.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic m;
    case (funct3)
      F3_LH, F3_LHU: m = off[0];
      F3_LW:         m = |off;
      default:       m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_ld_align.sv
// mem_ld_align: selects the addressed byte/halfword of a read word and
// sign- or zero-extends it; halfword lanes are chosen by offset[1] only.
module mem_ld_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension according to the access size.
  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   value = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  value = {24'd0, byte_sel};
      F3_LHU:  value = {16'd0, half_sel};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a request/acknowledge data-memory port,
// wait-cycle timeout and MEM/WB result registers.
// Optional build macro MEM_MISALIGN_CHK_EN enables misaligned-access trapping
// (misalign_err pulse, no request, bubble to WB); otherwise misalign_err is 0.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TO_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXE_ALU_out,
  input  logic [31:0] EXE_rs2_data,
  input  logic [31:0] EXE_pc_to_reg,
  input  logic [4:0]  EXE_rd_addr,
  input  logic [2:0]  EXE_funct3,
  input  logic        EXE_RDSrc,
  input  logic        EXE_MemtoReg,
  input  logic        EXE_MemRead,
  input  logic        EXE_MemWrite,
  input  logic        EXE_RegWrite,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] MEM_rd_data,
  output logic        mem_stall,
  output logic [31:0] WB_data,
  output logic [4:0]  WB_rd_addr,
  output logic        WB_RegWrite,
  output logic        bus_err,
  output logic        misalign_err
);

  // Counter holds 0 .. TO_CYC-1; the abort fires on the TO_CYC-th unacknowledged WAIT cycle.
  localparam int CNT_W = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);

  mem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Access latched on WAIT entry so the memory port stays stable until ack.
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic [31:0] fwd_q, fwd_d;

  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic        wb_regwrite_q, wb_regwrite_d;

  logic        stall_c, bus_err_c, misalign_c, mem_op, misal;
  logic [31:0] ld_val;
  st_lanes_t   lanes;

  assign MEM_rd_data = EXE_RDSrc ? EXE_pc_to_reg : EXE_ALU_out;
  assign mem_op      = EXE_MemRead | EXE_MemWrite;
  assign lanes       = store_lanes(EXE_funct3, EXE_ALU_out[1:0], EXE_rs2_data);

`ifdef MEM_MISALIGN_CHK_EN
  assign misal = mem_op & is_misaligned(EXE_funct3, EXE_ALU_out[1:0]);
`else
  assign misal = 1'b0;
`endif

  mem_ld_align u_ld_align (
    .word   (dm_rdata),
    .offset (off_q),
    .funct3 (funct3_q),
    .value  (ld_val)
  );

  // Next-state, access latching and WB capture for the IDLE/WAIT handshake.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    addr_d        = addr_q;
    off_d         = off_q;
    funct3_d      = funct3_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rd_addr_d     = rd_addr_q;
    regwrite_d    = regwrite_q;
    memtoreg_d    = memtoreg_q;
    fwd_d         = fwd_q;
    wb_data_d     = wb_data_q;
    wb_rd_addr_d  = wb_rd_addr_q;
    wb_regwrite_d = wb_regwrite_q;
    stall_c       = 1'b0;
    bus_err_c     = 1'b0;
    misalign_c    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!mem_op) begin
          wb_data_d     = MEM_rd_data;
          wb_rd_addr_d  = EXE_rd_addr;
          wb_regwrite_d = EXE_RegWrite;
        end else if (misal) begin
          misalign_c    = 1'b1;
          wb_regwrite_d = 1'b0;
        end else begin
          // A combined read+write request is carried out as a write.
          stall_c       = 1'b1;
          wb_regwrite_d = 1'b0;
          we_d          = EXE_MemWrite;
          addr_d        = EXE_ALU_out[31:2];
          off_d         = EXE_ALU_out[1:0];
          funct3_d      = EXE_funct3;
          wdata_d       = lanes.wdata;
          wstrb_d       = EXE_MemWrite ? lanes.wstrb : 4'b0000;
          rd_addr_d     = EXE_rd_addr;
          regwrite_d    = EXE_RegWrite;
          memtoreg_d    = EXE_MemtoReg;
          fwd_d         = MEM_rd_data;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (dm_ack) begin
          wb_data_d     = memtoreg_q ? ld_val : fwd_q;
          wb_rd_addr_d  = rd_addr_q;
          wb_regwrite_d = regwrite_q & ~we_q;
          cnt_d         = '0;
          state_d       = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_c     = 1'b1;
          wb_regwrite_d = 1'b0;
          cnt_d         = '0;
          state_d       = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched access and WB registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      off_q         <= '0;
      funct3_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rd_addr_q     <= '0;
      regwrite_q    <= 1'b0;
      memtoreg_q    <= 1'b0;
      fwd_q         <= '0;
      wb_data_q     <= '0;
      wb_rd_addr_q  <= '0;
      wb_regwrite_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      off_q         <= off_d;
      funct3_q      <= funct3_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rd_addr_q     <= rd_addr_d;
      regwrite_q    <= regwrite_d;
      memtoreg_q    <= memtoreg_d;
      fwd_q         <= fwd_d;
      wb_data_q     <= wb_data_d;
      wb_rd_addr_q  <= wb_rd_addr_d;
      wb_regwrite_q <= wb_regwrite_d;
    end
  end

  // Combinational outputs are gated with rst so reset silences them at once.
  assign dm_req       = (state_q == WAIT);
  assign dm_we        = dm_req & we_q;
  assign dm_addr      = {addr_q, 2'b00};
  assign dm_wstrb     = dm_req ? wstrb_q : 4'b0000;
  assign dm_wdata     = wdata_q;
  assign mem_stall    = stall_c & rst;
  assign bus_err      = bus_err_c & rst;
  assign misalign_err = misalign_c & rst;
  assign WB_data      = wb_data_q;
  assign WB_rd_addr   = wb_rd_addr_q;
  assign WB_RegWrite  = wb_regwrite_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage (TO_CYC = 4). Expected WB and
// handshake results are pushed when an instruction is driven and popped when
// it leaves the stage. Honors MEM_MISALIGN_CHK_EN if the build defines it.
`timescale 1ns/1ps
module tb_mem_stage;

  localparam int TB_TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] EXE_ALU_out, EXE_rs2_data, EXE_pc_to_reg;
  logic [4:0]  EXE_rd_addr;
  logic [2:0]  EXE_funct3;
  logic        EXE_RDSrc, EXE_MemtoReg, EXE_MemRead, EXE_MemWrite, EXE_RegWrite;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] MEM_rd_data, WB_data;
  logic        mem_stall, WB_RegWrite, bus_err, misalign_err;
  logic [4:0]  WB_rd_addr;

  always #5 clk = ~clk;

  mem_stage #(.TO_CYC(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .EXE_ALU_out(EXE_ALU_out), .EXE_rs2_data(EXE_rs2_data), .EXE_pc_to_reg(EXE_pc_to_reg),
    .EXE_rd_addr(EXE_rd_addr), .EXE_funct3(EXE_funct3),
    .EXE_RDSrc(EXE_RDSrc), .EXE_MemtoReg(EXE_MemtoReg), .EXE_MemRead(EXE_MemRead),
    .EXE_MemWrite(EXE_MemWrite), .EXE_RegWrite(EXE_RegWrite),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .MEM_rd_data(MEM_rd_data), .mem_stall(mem_stall),
    .WB_data(WB_data), .WB_rd_addr(WB_rd_addr), .WB_RegWrite(WB_RegWrite),
    .bus_err(bus_err), .misalign_err(misalign_err)
  );

  typedef struct {
    logic [31:0] alu, rs2, pc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rdsrc, m2r, mrd, mwr, rw;
  } instr_t;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    int          stalls, reqs, berr, merr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_ops    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] rs2,
                                input logic [2:0] f3, input logic mrd, input logic mwr,
                                input logic m2r, input logic [4:0] rd);
    instr_t i;
    i.alu = alu; i.rs2 = rs2; i.pc = 32'h0000_0400 + {alu[15:0], 2'b00};
    i.rd = rd; i.f3 = f3; i.rdsrc = 1'b0; i.m2r = m2r;
    i.mrd = mrd; i.mwr = mwr; i.rw = 1'b1;
    return i;
  endfunction

  // Reference behaviour built lane by lane from the access size.
  function automatic exp_t model(input instr_t i, input int ack_after, input logic [31:0] rdata);
    exp_t e;
    logic mis;
    logic [7:0] b [4];
    int o;
    e.rw = i.rw; e.rd = i.rd; e.data = i.rdsrc ? i.pc : i.alu;
    e.stalls = 0; e.reqs = 0; e.berr = 0; e.merr = 0;
    e.addr = {i.alu[31:2], 2'b00}; e.strb = 4'b0000; e.wdata = 32'd0;
    if (!(i.mrd || i.mwr)) return e;
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
    if ((i.f3 == 3'd1 || i.f3 == 3'd5) && i.alu[0]) mis = 1'b1;
    if (i.f3 == 3'd2 && i.alu[1:0] != 2'd0) mis = 1'b1;
`endif
    if (mis) begin e.rw = 1'b0; e.merr = 1; return e; end
    if (ack_after < 0) begin
      e.rw = 1'b0; e.berr = 1; e.stalls = TB_TO; e.reqs = TB_TO;
      return e;
    end
    e.stalls = ack_after + 1;
    e.reqs   = ack_after + 1;
    o = int'(i.alu[1:0]);
    if (i.mwr) begin
      e.rw = 1'b0;
      for (int k = 0; k < 4; k++) begin
        case (i.f3)
          3'd0: begin
            e.strb[k] = (k == o);
            e.wdata[8*k +: 8] = i.rs2[7:0];
          end
          3'd1: begin
            e.strb[k] = ((k / 2) == (o / 2));
            e.wdata[8*k +: 8] = (k % 2 == 0) ? i.rs2[7:0] : i.rs2[15:8];
          end
          default: begin
            e.strb[k] = 1'b1;
            e.wdata[8*k +: 8] = i.rs2[8*k +: 8];
          end
        endcase
      end
    end else if (i.m2r) begin
      for (int k = 0; k < 4; k++) b[k] = rdata[8*k +: 8];
      case (i.f3)
        3'd0:    e.data = {{24{b[o][7]}}, b[o]};
        3'd4:    e.data = {24'd0, b[o]};
        3'd1:    e.data = {{16{b[2*(o/2)+1][7]}}, b[2*(o/2)+1], b[2*(o/2)]};
        3'd5:    e.data = {16'd0, b[2*(o/2)+1], b[2*(o/2)]};
        default: e.data = rdata;
      endcase
    end
    return e;
  endfunction

  // Drives one instruction from posedge+1, answers the memory port and
  // compares the WB registers once the stage releases the instruction.
  task automatic run_op(input instr_t in, input int ack_after, input logic [31:0] rdata);
    exp_t e, got;
    int stalls = 0, reqs = 0, berr = 0, merr = 0, cyc = 0;
    bit done = 0;
    e = model(in, ack_after, rdata);
    sb_q.push_back(e);
    EXE_ALU_out = in.alu; EXE_rs2_data = in.rs2; EXE_pc_to_reg = in.pc;
    EXE_rd_addr = in.rd; EXE_funct3 = in.f3; EXE_RDSrc = in.rdsrc;
    EXE_MemtoReg = in.m2r; EXE_MemRead = in.mrd; EXE_MemWrite = in.mwr;
    EXE_RegWrite = in.rw;
    while (!done) begin
      dm_ack = 1'b0;
      dm_rdata = 32'hDEAD_BEEF;
      if (dm_req) begin
        reqs++;
        if (ack_after >= 0 && reqs > ack_after) begin
          dm_ack = 1'b1;
          dm_rdata = rdata;
        end
      end
      #4;
      if (cyc == 0) check("fwd_value", MEM_rd_data, in.rdsrc ? in.pc : in.alu);
      if (dm_req) begin
        check("dm_addr", dm_addr, e.addr);
        check("dm_we", {31'd0, dm_we}, {31'd0, in.mwr});
        check("dm_wstrb", {28'd0, dm_wstrb}, {28'd0, e.strb});
        if (in.mwr) check("dm_wdata", dm_wdata, e.wdata);
      end
      if (mem_stall) stalls++;
      else done = 1;
      if (bus_err) berr++;
      if (misalign_err) merr++;
      @(posedge clk);
      #1;
      dm_ack = 1'b0;
      cyc++;
      if (!done && cyc > 50) begin
        check("op_cycle_bound", 32'(cyc), 32'd50);
        done = 1;
      end
    end
    got = sb_q.pop_front();
    check("wb_regwrite", {31'd0, WB_RegWrite}, {31'd0, got.rw});
    if (got.rw) begin
      check("wb_rd_addr", {27'd0, WB_rd_addr}, {27'd0, got.rd});
      check("wb_data", WB_data, got.data);
    end
    check("stall_cycles", 32'(stalls), 32'(got.stalls));
    check("req_cycles", 32'(reqs), 32'(got.reqs));
    check("bus_err_pulses", 32'(berr), 32'(got.berr));
    check("misalign_pulses", 32'(merr), 32'(got.merr));
    n_ops++;
    $display("op %0d: addr=%08h f3=%0d rd=%0b wr=%0b ack_after=%0d -> wb_we=%0b wb_data=%08h stalls=%0d",
             n_ops, in.alu, in.f3, in.mrd, in.mwr, ack_after, WB_RegWrite, WB_data, stalls);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t in;
    int kind;
    logic [2:0] lf3 [5];
    lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2; lf3[3] = 3'd4; lf3[4] = 3'd5;

    // Reset with a memory op presented: everything must stay quiet.
    rst = 1'b0;
    dm_ack = 1'b0; dm_rdata = 32'd0;
    in = mk(32'h0000_3002, 32'd0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd9);
    EXE_ALU_out = in.alu; EXE_rs2_data = in.rs2; EXE_pc_to_reg = in.pc;
    EXE_rd_addr = in.rd; EXE_funct3 = in.f3; EXE_RDSrc = 1'b0;
    EXE_MemtoReg = 1'b1; EXE_MemRead = 1'b1; EXE_MemWrite = 1'b0; EXE_RegWrite = 1'b1;
    #2;
    check("rst_dm_req", {31'd0, dm_req}, 32'd0);
    check("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_dm_wstrb", {28'd0, dm_wstrb}, 32'd0);
    @(posedge clk); #1;
    check("rst_wb_data", WB_data, 32'd0);
    check("rst_wb_we", {31'd0, WB_RegWrite}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    EXE_MemRead = 1'b0; EXE_MemtoReg = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // ALU op, then SB 0x1003 with ack after 2 wait cycles.
    run_op(mk(32'h0000_0042, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd1), 0, 32'd0);
    check("alu_wb_data", WB_data, 32'h0000_0042);
    in = mk(32'h0000_1003, 32'h0000_00A5, 3'd0, 1'b0, 1'b1, 1'b0, 5'd5);
    run_op(in, 2, 32'd0);

    // LB / LBU at 0x2001 with immediate ack.
    run_op(mk(32'h0000_2001, 32'd0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd7), 0, 32'h0000_8000);
    check("lb_value", WB_data, 32'hFFFF_FF80);
    run_op(mk(32'h0000_2001, 32'd0, 3'd4, 1'b1, 1'b0, 1'b1, 5'd8), 0, 32'h0000_8000);
    check("lbu_value", WB_data, 32'h0000_0080);

    // Halfword loads, combined read+write treated as SH.
    run_op(mk(32'h0000_6002, 32'd0, 3'd5, 1'b1, 1'b0, 1'b1, 5'd10), 1, 32'h8765_4321);
    check("lhu_value", WB_data, 32'h0000_8765);
    run_op(mk(32'h0000_6000, 32'd0, 3'd1, 1'b1, 1'b0, 1'b1, 5'd11), 0, 32'h0000_F00D);
    check("lh_value", WB_data, 32'hFFFF_F00D);
    run_op(mk(32'h0000_5002, 32'h1234_BEEF, 3'd1, 1'b1, 1'b1, 1'b1, 5'd12), 1, 32'd0);

    // LW never acknowledged: timeout after TB_TO wait cycles.
    run_op(mk(32'h0000_2000, 32'd0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd13), -1, 32'd0);

    // LW at 0x3002: trapped when the check is built in, a normal access otherwise.
    run_op(mk(32'h0000_3002, 32'd0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd14), 0, 32'hCAFE_F00D);

    // Reset in the middle of WAIT abandons the access.
    in = mk(32'h0000_4000, 32'd0, 3'd2, 1'b1, 1'b0, 1'b1, 5'd15);
    EXE_ALU_out = in.alu; EXE_funct3 = in.f3; EXE_rd_addr = in.rd;
    EXE_MemRead = 1'b1; EXE_MemtoReg = 1'b1; EXE_MemWrite = 1'b0; EXE_RegWrite = 1'b1;
    dm_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_dm_req", {31'd0, dm_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_dm_req", {31'd0, dm_req}, 32'd0);
    check("midrst_mem_stall", {31'd0, mem_stall}, 32'd0);
    check("midrst_wb_we", {31'd0, WB_RegWrite}, 32'd0);
    check("midrst_bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    in = mk(32'h1234_5678, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd3);
    EXE_ALU_out = in.alu; EXE_pc_to_reg = in.pc; EXE_rd_addr = in.rd;
    EXE_MemRead = 1'b0; EXE_MemtoReg = 1'b0; EXE_MemWrite = 1'b0; EXE_RegWrite = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_dm_req", {31'd0, dm_req}, 32'd0);
    run_op(in, 0, 32'd0);
    check("post_rst_add", WB_data, 32'h1234_5678);

    // Randomised mix of ALU ops, loads and stores.
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 0) begin
        in = mk($urandom, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'($urandom_range(1, 31)));
        in.rdsrc = 1'($urandom_range(0, 1));
      end else if (kind == 1) begin
        in = mk($urandom, 32'd0, lf3[$urandom_range(0, 4)], 1'b1, 1'b0, 1'b1,
                5'($urandom_range(1, 31)));
      end else begin
        in = mk($urandom, $urandom, 3'($urandom_range(0, 2)), 1'b0, 1'b1, 1'b0,
                5'($urandom_range(1, 31)));
      end
      run_op(in, int'($urandom_range(0, 2)), $urandom);
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
